// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
// Define MC_MAIN_CONTROL_ILLOP_EN to trap unknown opcodes in TRAP with an illegal_op flag.
module mc_main_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
`ifdef MC_MAIN_CONTROL_ILLOP_EN
  output logic               illegal_op,
`endif
  output logic [STATE_W-1:0] dbg_state
);

  localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_ADDIEX = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_ADDIWB = STATE_W'(11);
`ifdef MC_MAIN_CONTROL_ILLOP_EN
  localparam logic [STATE_W-1:0] S_TRAP   = STATE_W'(12);
`endif

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  logic [STATE_W-1:0] state_reg, state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDIEX;
`ifdef MC_MAIN_CONTROL_ILLOP_EN
          default:      state_next = S_TRAP;
`else
          default:      state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next = S_ALUWB;
      S_ADDIEX: state_next = S_ADDIWB;
`ifdef MC_MAIN_CONTROL_ILLOP_EN
      S_TRAP:   state_next = S_TRAP;
`endif
      default:  state_next = S_FETCH;
    endcase
  end

  logic       pc_write_dec, pc_write_cond_dec, i_or_d_dec, mem_read_dec, mem_write_dec;
  logic       ir_write_dec, mem_to_reg_dec, reg_dst_dec, reg_write_dec, alu_src_a_dec;
  logic [1:0] alu_src_b_dec, alu_op_dec, pc_source_dec;

  always_comb begin
    pc_write_dec      = 1'b0;
    pc_write_cond_dec = 1'b0;
    i_or_d_dec        = 1'b0;
    mem_read_dec      = 1'b0;
    mem_write_dec     = 1'b0;
    ir_write_dec      = 1'b0;
    mem_to_reg_dec    = 1'b0;
    reg_dst_dec       = 1'b0;
    reg_write_dec     = 1'b0;
    alu_src_a_dec     = 1'b0;
    alu_src_b_dec     = 2'b00;
    alu_op_dec        = 2'b00;
    pc_source_dec     = 2'b00;
    case (state_reg)
      S_FETCH: begin
        mem_read_dec  = 1'b1;
        alu_src_b_dec = 2'b01;
        ir_write_dec  = mem_ready;
        pc_write_dec  = mem_ready;
      end
      S_DECODE: alu_src_b_dec = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a_dec = 1'b1;
        alu_src_b_dec = 2'b10;
      end
      S_MEMRD: begin
        mem_read_dec = 1'b1;
        i_or_d_dec   = 1'b1;
      end
      S_MEMWB: begin
        reg_write_dec  = 1'b1;
        mem_to_reg_dec = 1'b1;
      end
      S_MEMWR: begin
        mem_write_dec = 1'b1;
        i_or_d_dec    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_dec = 1'b1;
        alu_op_dec    = 2'b10;
      end
      S_ALUWB: begin
        reg_write_dec = 1'b1;
        reg_dst_dec   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_dec     = 1'b1;
        alu_op_dec        = 2'b01;
        pc_write_cond_dec = 1'b1;
        pc_source_dec     = 2'b01;
      end
      S_JUMP: begin
        pc_write_dec  = 1'b1;
        pc_source_dec = 2'b10;
      end
      S_ADDIWB: reg_write_dec = 1'b1;
      default: ;
    endcase
  end

  // Gate with rst_n so a mid-instruction reset kills requests/writes in the same cycle.
  assign pc_write      = rst_n & pc_write_dec;
  assign pc_write_cond = rst_n & pc_write_cond_dec;
  assign i_or_d        = rst_n & i_or_d_dec;
  assign mem_read      = rst_n & mem_read_dec;
  assign mem_write     = rst_n & mem_write_dec;
  assign ir_write      = rst_n & ir_write_dec;
  assign mem_to_reg    = rst_n & mem_to_reg_dec;
  assign reg_dst       = rst_n & reg_dst_dec;
  assign reg_write     = rst_n & reg_write_dec;
  assign alu_src_a     = rst_n & alu_src_a_dec;
  assign alu_src_b     = rst_n ? alu_src_b_dec : 2'b00;
  assign alu_op        = rst_n ? alu_op_dec    : 2'b00;
  assign pc_source     = rst_n ? pc_source_dec : 2'b00;
  assign dbg_state     = state_reg;
`ifdef MC_MAIN_CONTROL_ILLOP_EN
  assign illegal_op    = rst_n && (state_reg == S_TRAP);
`endif

endmodule
